muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer between the CPU pipeline and the multi-cycle multiply and divide units. It owns the architectural HI/LO registers and issues start pulses with stable operands. It waits for each unit's done pulse and stalls dependent instructions (MFHI/MFLO/MTHI/MTLO, new MULT/DIV) until the result has landed. Divide-by-zero is detected here, and a watchdog recovers from a unit that never finishes.

Parameters:
TIMEOUT_CYCLES, 63, cycles allowed in a busy state before abort (must exceed the 32-cycle divider latency)
CNT_W, 6, watchdog counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
op_valid  in  1  CPU presents an operation this cycle
op  in  3  operation code (package constants)
rs_data  in  32  operand A / dividend / MT source
rt_data  in  32  operand B / divisor
op_stall  out  1  CPU must hold the operation (combinational)
mf_data  out  32  MFHI/MFLO result, valid when op_valid & ~op_stall
div_zero  out  1  one-cycle pulse: DIV with rt_data==0 accepted
timeout_err  out  1  sticky watchdog abort flag
div_start  out  1  one-cycle start pulse to divider
div_dividend  out  32  registered dividend
div_divisor  out  32  registered divisor
div_end  in  1  divider done pulse
div_hi  in  32  divider remainder
div_lo  in  32  divider quotient
mult_start  out  1  one-cycle start pulse to multiplier
mult_a  out  32  registered operand
mult_b  out  32  registered operand
mult_end  in  1  multiplier done pulse
mult_hi  in  32  product [63:32]
mult_lo  in  32  product [31:0]
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset state: IDLE. hi, lo, div_dividend, div_divisor, mult_a, mult_b = 0. div_start, mult_start, div_zero, timeout_err = 0.
- States: IDLE, DIV_ISSUE, DIV_WAIT, MULT_ISSUE, MULT_WAIT.
- IDLE, op_valid, op=DIV, rt_data!=0: latch operands; next state DIV_ISSUE; op_stall=0 (instruction retires).
- IDLE, DIV with rt_data==0: pulse div_zero next cycle. No start, HI/LO unchanged, stay IDLE.
- IDLE, op=MULT: latch operands; next state MULT_ISSUE.
- DIV_ISSUE / MULT_ISSUE: assert the matching start pulse for exactly 1 cycle, clear the watchdog, go to the matching WAIT state. Operands stay stable until return to IDLE.
- DIV_WAIT: on div_end, hi<=div_hi and lo<=div_lo; next state IDLE.
- MULT_WAIT: same using mult_end, mult_hi, mult_lo.
- Done pulses are ignored outside their WAIT state.
- IDLE, MFHI/MFLO: mf_data = hi/lo combinationally, no stall.
- IDLE, MTHI/MTLO: hi/lo <= rs_data at the clock edge.
- op_stall = op_valid & (op != NONE) & (state != IDLE).
  - The completion cycle still stalls. The held op is accepted the cycle after, with the new HI/LO visible.
- Watchdog: counts in WAIT states. When it reaches TIMEOUT_CYCLES, go to IDLE, set timeout_err (sticky until rst), HI/LO unchanged.
- rst mid-operation: return to IDLE and clear HI/LO immediately. The divider shares rst, so no stale done pulse is accepted.
- Undefined op codes: treated as NONE (no stall, no effect).

Decomposition:
- Package muldiv_pkg holds:
  - op constants: OP_NONE=0, OP_MULT=1, OP_DIV=2, OP_MFHI=3, OP_MFLO=4, OP_MTHI=5, OP_MTLO=6
  - the state encoding
  - the TIMEOUT_CYCLES default
- One natural sub-module: muldiv_watchdog (clear, enable, CNT_W counter, expired output).

Test Plan:
- DIV 100/7, then MFLO held immediately -> op_stall high until div_end+1; then mf_data=14; MFHI gives 2.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_start high exactly 1 cycle.
- DIV rs=5, rt=0 after MTHI 0xAAAA_AAAA -> div_zero pulses 1 cycle, no div_start, hi stays 0xAAAAAAAA.
- MULT 0x00010000*0x00010000 -> hi=1, lo=0; second MULT issued while busy stalls until completion.
- Stub divider that never raises div_end -> after 63 WAIT cycles state returns to IDLE, timeout_err=1, HI/LO unchanged.
- rst asserted mid DIV_WAIT -> next cycle hi=lo=0, op_stall=0; a later div_end pulse is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encoding and default watchdog sizing.
package muldiv_pkg;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MFHI = 3'd3;
  localparam logic [2:0] OP_MFLO = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5;
  localparam logic [2:0] OP_MTLO = 3'd6;

  localparam int TIMEOUT_CYCLES_DEF = 63;
  localparam int CNT_W_DEF          = 6;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DIV_ISSUE  = 3'd1,
    ST_DIV_WAIT   = 3'd2,
    ST_MULT_ISSUE = 3'd3,
    ST_MULT_WAIT  = 3'd4
  } state_e;

  // Codes outside MULT..MTLO behave exactly like OP_NONE.
  function automatic logic is_real_op(input logic [2:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Busy-state watchdog: counts enabled cycles and flags expiry on the
// LIMIT-th consecutive enabled cycle since the last clear.
module muldiv_watchdog #(
  parameter int CNT_W = 6,
  parameter int LIMIT = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;

  assign expired_o = enable_i && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer owning HI/LO: issues start pulses to the multiply/divide units,
// stalls dependent ops until results land, and aborts hung units.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        op_stall,
  output logic [31:0] mf_data,
  output logic        div_zero,
  output logic        timeout_err,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_end,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_end,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, lo_q;
  logic [31:0] div_dividend_q, div_divisor_q, mult_a_q, mult_b_q;
  logic        div_zero_q, timeout_err_q;
  logic        idle_op, div_ok, div_by_zero, div_done, mult_done;
  logic        wd_clear, wd_enable, wd_expired;

  muldiv_watchdog #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (div_ok)                           state_d = ST_DIV_ISSUE;
        else if (idle_op && op == OP_MULT)    state_d = ST_MULT_ISSUE;
      end
      ST_DIV_ISSUE:  state_d = ST_DIV_WAIT;
      ST_DIV_WAIT:   if (div_end || wd_expired)  state_d = ST_IDLE;
      ST_MULT_ISSUE: state_d = ST_MULT_WAIT;
      ST_MULT_WAIT:  if (mult_end || wd_expired) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle_op     = (state_q == ST_IDLE) && op_valid;
    div_ok      = idle_op && (op == OP_DIV) && (rt_data != '0);
    div_by_zero = idle_op && (op == OP_DIV) && (rt_data == '0);
    div_done    = (state_q == ST_DIV_WAIT) && div_end;
    mult_done   = (state_q == ST_MULT_WAIT) && mult_end;
    op_stall    = op_valid && is_real_op(op) && (state_q != ST_IDLE);
    div_start   = (state_q == ST_DIV_ISSUE);
    mult_start  = (state_q == ST_MULT_ISSUE);
    wd_clear    = div_start || mult_start;
    wd_enable   = (state_q == ST_DIV_WAIT) || (state_q == ST_MULT_WAIT);
    mf_data     = '0;
    if (op == OP_MFHI)      mf_data = hi_q;
    else if (op == OP_MFLO) mf_data = lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q           <= '0;
      lo_q           <= '0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      mult_a_q       <= '0;
      mult_b_q       <= '0;
      div_zero_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      div_zero_q <= div_by_zero;
      if (div_ok) begin
        div_dividend_q <= rs_data;
        div_divisor_q  <= rt_data;
      end
      if (idle_op && op == OP_MULT) begin
        mult_a_q <= rs_data;
        mult_b_q <= rt_data;
      end
      if (idle_op && op == OP_MTHI) hi_q <= rs_data;
      if (idle_op && op == OP_MTLO) lo_q <= rs_data;
      if (div_done) begin
        hi_q <= div_hi;
        lo_q <= div_lo;
      end
      if (mult_done) begin
        hi_q <= mult_hi;
        lo_q <= mult_lo;
      end
      // A done pulse arriving on the expiry cycle still wins.
      if (wd_expired && !div_done && !mult_done) timeout_err_q <= 1'b1;
    end
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign div_zero     = div_zero_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized checks of muldiv_ctrl against an arithmetic model,
// with behavioural stub multiply/divide units driven from the bench.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        op_stall, div_zero, timeout_err, div_start, mult_start;
  logic [31:0] mf_data, div_dividend, div_divisor, mult_a, mult_b, hi, lo;
  logic        div_end, mult_end;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .op_stall(op_stall), .mf_data(mf_data),
    .div_zero(div_zero), .timeout_err(timeout_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_end(div_end), .div_hi(div_hi), .div_lo(div_lo),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_end(mult_end), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] hi_m, lo_m;
  bit  div_never = 0;
  int  div_lat = 4, mult_lat = 4;
  int  div_starts = 0, mult_starts = 0;
  int  inject_req = 0;

  function automatic logic [63:0] sdivmod(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    sa = a; sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return pa * pb;
  endfunction

  // Stub units: results appear `lat` cycles after the start pulse.
  initial begin : responder
    int dcnt, mcnt, inject_done;
    logic [63:0] res;
    dcnt = 0; mcnt = 0; inject_done = 0;
    div_end = 0; mult_end = 0;
    div_hi = '0; div_lo = '0; mult_hi = '0; mult_lo = '0;
    forever begin
      @(negedge clk);
      div_end = 0;
      mult_end = 0;
      if (rst) begin
        dcnt = 0;
        mcnt = 0;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) div_end = 1;
        end
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) mult_end = 1;
        end
        if (div_start) begin
          div_starts++;
          if (!div_never) begin
            dcnt = div_lat;
            res = sdivmod(div_dividend, div_divisor);
            div_hi = res[63:32];
            div_lo = res[31:0];
          end
        end
        if (mult_start) begin
          mult_starts++;
          mcnt = mult_lat;
          res = smul(mult_a, mult_b);
          mult_hi = res[63:32];
          mult_lo = res[31:0];
        end
        if (inject_req != inject_done) begin
          inject_done = inject_req;
          div_end = 1;
          div_hi = 32'h1234_5678;
          div_lo = 32'h9ABC_DEF0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents an op at posedge+1 and holds it until accepted.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic [31:0] mf);
    op_valid = 1; op = o; rs_data = a; rt_data = b; stalls = 0;
    #1;
    while (op_stall && stalls < 200) begin
      @(posedge clk); #1;
      stalls++;
    end
    mf = mf_data;
    @(posedge clk); #1;
    op_valid = 0; op = OP_NONE;
  endtask

  task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    case (o)
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      OP_DIV:  if (b != 0) begin r = sdivmod(a, b); hi_m = r[63:32]; lo_m = r[31:0]; end
      OP_MULT: begin r = smul(a, b); hi_m = r[63:32]; lo_m = r[31:0]; end
      default: ;
    endcase
  endtask

  initial begin : main
    int st;
    logic [31:0] mf, a, b;
    logic [2:0]  o;
    rst = 1; op_valid = 0; op = OP_NONE; rs_data = '0; rt_data = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_divisor", div_divisor, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_starts", {30'd0, div_start, mult_start}, 0);
    chk("rst_flags", {30'd0, div_zero, timeout_err}, 0);
    rst = 0;
    @(posedge clk); #1;

    // DIV 100/7 followed immediately by a held MFLO
    div_lat = 5;
    issue(OP_DIV, 100, 7, st, mf);
    chk("div1_accept_stall", st, 0);
    chk("div1_start", div_start, 1);
    chk("div1_dividend", div_dividend, 100);
    chk("div1_divisor", div_divisor, 7);
    model_apply(OP_DIV, 100, 7);
    issue(OP_MFLO, 0, 0, st, mf);
    chk("div1_mflo_stalls", st, div_lat + 1);
    chk("div1_mflo", mf, lo_m);
    issue(OP_MFHI, 0, 0, st, mf);
    chk("div1_mfhi_stall", st, 0);
    chk("div1_mfhi", mf, hi_m);

    // Signed DIV -7/2; undefined op while busy must not stall
    div_lat = $urandom_range(1, 32);
    issue(OP_DIV, 32'hFFFF_FFF9, 2, st, mf);
    model_apply(OP_DIV, 32'hFFFF_FFF9, 2);
    op_valid = 1; op = 3'd7; #1;
    chk("undef_op_no_stall", op_stall, 0);
    op_valid = 0; op = OP_NONE;
    issue(OP_MFLO, 0, 0, st, mf);
    chk("div2_mflo_stalls", st, div_lat + 1);
    chk("div2_lo_port", lo, lo_m);
    chk("div2_hi_port", hi, hi_m);
    chk("div2_start_count", div_starts, 2);

    // Divide by zero after MTHI
    issue(OP_MTHI, 32'hAAAA_AAAA, 0, st, mf);
    model_apply(OP_MTHI, 32'hAAAA_AAAA, 0);
    issue(OP_DIV, 5, 0, st, mf);
    chk("dz_pulse", div_zero, 1);
    @(posedge clk); #1;
    chk("dz_pulse_end", div_zero, 0);
    repeat (2) @(posedge clk); #1;
    chk("dz_no_start", div_starts, 2);
    chk("dz_hi_kept", hi, hi_m);

    // MULT, then a second MULT held while busy
    mult_lat = $urandom_range(1, 20);
    issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, st, mf);
    model_apply(OP_MULT, 32'h0001_0000, 32'h0001_0000);
    a = $urandom; b = $urandom;
    issue(OP_MULT, a, b, st, mf);
    chk("mult2_stalls", st, mult_lat + 1);
    chk("mult1_hi", hi, hi_m);
    chk("mult1_lo", lo, lo_m);
    model_apply(OP_MULT, a, b);
    issue(OP_MFHI, 0, 0, st, mf);
    chk("mult2_mfhi", mf, hi_m);
    issue(OP_MFLO, 0, 0, st, mf);
    chk("mult2_mflo", mf, lo_m);
    chk("mult_start_count", mult_starts, 2);

    // Random op stream against the model
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0: o = OP_MULT;
        1: o = OP_DIV;
        2: o = OP_MTHI;
        default: o = OP_MTLO;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 1;
      div_lat = $urandom_range(1, 32);
      mult_lat = $urandom_range(1, 32);
      issue(o, a, b, st, mf);
      model_apply(o, a, b);
      issue(OP_MFHI, 0, 0, st, mf);
      chk($sformatf("rand%0d_hi", i), mf, hi_m);
      issue(OP_MFLO, 0, 0, st, mf);
      chk($sformatf("rand%0d_lo", i), mf, lo_m);
    end

    // Divider that never finishes
    div_never = 1;
    issue(OP_DIV, 9, 3, st, mf);
    issue(OP_MFLO, 0, 0, st, mf);
    chk("wd_stalls", st, 1 + TIMEOUT_CYCLES_DEF);
    chk("wd_err", timeout_err, 1);
    chk("wd_lo_kept", mf, lo_m);
    chk("wd_hi_kept", hi, hi_m);
    div_never = 0;
    issue(OP_MTLO, 32'h5555_0000, 0, st, mf);
    model_apply(OP_MTLO, 32'h5555_0000, 0);
    chk("wd_err_sticky", timeout_err, 1);
    chk("wd_mtlo_after", lo, lo_m);

    // Reset in the middle of DIV_WAIT, then a stale done pulse
    div_never = 1;
    issue(OP_DIV, 50, 5, st, mf);
    repeat (3) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    hi_m = '0; lo_m = '0;
    chk("mrst_hi", hi, hi_m);
    chk("mrst_lo", lo, lo_m);
    chk("mrst_err_clear", timeout_err, 0);
    op_valid = 1; op = OP_MFHI; #1;
    chk("mrst_no_stall", op_stall, 0);
    op_valid = 0; op = OP_NONE;
    inject_req++;
    repeat (3) @(posedge clk); #1;
    chk("stale_end_hi", hi, hi_m);
    chk("stale_end_lo", lo, lo_m);
    div_never = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : guard
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
